// File: rtl/instruction_sequencer.sv
// Program sequencer that feeds Excutor: holds a small program RAM and issues one
// opcode at a time, advancing only after Excutor signals Done.
module instruction_sequencer #(
  parameter int OP_W  = 20,
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            LoadEn,
  input  logic [AW-1:0]   LoadAddr,
  input  logic [OP_W-1:0] LoadData,
  input  logic [AW:0]     ProgLen,
  input  logic            Start,
  input  logic            Done,
  output logic [OP_W-1:0] OpCode,
  output logic [AW:0]     Pc,
  output logic [15:0]     Issued,
  output logic            Running,
  output logic            Halted
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_LOW  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_HALT      = 3'd4;

  localparam logic [AW:0] PC_END = (AW+1)'(DEPTH);

  logic [2:0]      state;
  logic [AW:0]     len;
  logic [OP_W-1:0] ram [DEPTH];
  logic [OP_W-1:0] rd_word;
  logic [AW:0]     pc_next;
  logic            ctrl_ok;

  assign ctrl_ok = (state == S_IDLE) || (state == S_HALT);
  assign rd_word = ram[Pc[AW-1:0]];
  assign pc_next = Pc + (AW+1)'(1);
  assign Running = (state == S_ISSUE) || (state == S_WAIT_LOW) || (state == S_WAIT_DONE);
  assign Halted  = (state == S_HALT);

  // NOTE: the program RAM has no reset so it maps onto plain memory; its
  // contents deliberately survive Reset.
  always_ff @(posedge Clock) begin
    if (LoadEn && ctrl_ok)
      ram[LoadAddr] <= LoadData;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= S_IDLE;
      len    <= '0;
      OpCode <= '0;
      Pc     <= '0;
      Issued <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          OpCode <= '0;
          if (Start) begin
            if (ProgLen == '0) begin
              state <= S_HALT;
            end else begin
              len    <= ProgLen;
              Pc     <= '0;
              Issued <= '0;
              state  <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          // A zero word is the halt opcode and is never presented to Excutor.
          if (rd_word == '0) begin
            OpCode <= '0;
            state  <= S_HALT;
          end else begin
            OpCode <= rd_word;
            if (Issued != 16'hFFFF)
              Issued <= Issued + 16'd1;
            state <= S_WAIT_LOW;
          end
        end

        S_WAIT_LOW: begin
          if (!Done)
            state <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          if (Done) begin
            Pc <= pc_next;
            if ((pc_next == len) || (pc_next == PC_END)) begin
              OpCode <= '0;
              state  <= S_HALT;
            end else begin
              state <= S_ISSUE;
            end
          end
        end

        default: begin
          OpCode <= '0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: table-driven program runs plus
// hand-written reset, load/start collision and full-depth sequences.
module tb_instruction_sequencer;

  localparam int OP_W  = 20;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic            Clock = 1'b0;
  logic            Reset = 1'b1;
  logic            LoadEn = 1'b0;
  logic [AW-1:0]   LoadAddr = '0;
  logic [OP_W-1:0] LoadData = '0;
  logic [AW:0]     ProgLen = '0;
  logic            Start = 1'b0;
  logic            Done = 1'b1;
  logic [OP_W-1:0] OpCode;
  logic [AW:0]     Pc;
  logic [15:0]     Issued;
  logic            Running;
  logic            Halted;

  int checks = 0;
  int errors = 0;

  logic [OP_W-1:0] exp_ops [DEPTH];
  int              exp_n;

  typedef struct {
    string           name;
    bit              load;
    logic [OP_W-1:0] w0, w1, w2;
    logic [AW:0]     len;
    bit              poke;
    int              n_issue;
    logic [AW:0]     pc_end;
  } vec_t;

  vec_t vecs [4];

  instruction_sequencer #(.OP_W(OP_W), .AW(AW), .DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
    .LoadData(LoadData), .ProgLen(ProgLen), .Start(Start), .Done(Done),
    .OpCode(OpCode), .Pc(Pc), .Issued(Issued), .Running(Running), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [OP_W-1:0] d);
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    tick();
    LoadEn = 1'b0;
  endtask

  task automatic start(input logic [AW:0] len);
    ProgLen = len; Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Excutor model: entered right after the Start edge (DUT in ISSUE).
  // Returns the number of instructions observed before HALT.
  task automatic serve(input string tag, input bit poke, output int n);
    bit fin;
    logic [OP_W-1:0] held;
    n = 0;
    fin = 1'b0;
    for (int guard = 0; guard < 200 && !fin; guard++) begin
      tick();                                   // ISSUE edge
      if (Halted) begin
        fin = 1'b1;
      end else begin
        held = OpCode;
        if (n < exp_n) check({tag, "_op"}, 32'(OpCode), 32'(exp_ops[n]));
        else           check({tag, "_extra_issue"}, 32'(n), 32'(exp_n));
        check({tag, "_pc"}, 32'(Pc), 32'(n));
        tick();                                 // Done still high in WAIT_LOW
        check({tag, "_glitch_pc"}, 32'(Pc), 32'(n));
        Done = 1'b0;
        tick();                                 // enters WAIT_DONE
        if (poke && n == 0) begin
          LoadEn = 1'b1; LoadAddr = 6'd1; LoadData = 20'hFF;
          Start = 1'b1; ProgLen = 7'd1;
          tick();
          LoadEn = 1'b0; Start = 1'b0;
          check({tag, "_poke_running"}, 32'(Running), 32'd1);
        end
        check({tag, "_hold"}, 32'(OpCode), 32'(held));
        Done = 1'b1;
        tick();                                 // to ISSUE or HALT
        n++;
        if (Halted) fin = 1'b1;
      end
    end
    if (!fin) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    vecs[0] = '{"three_op",     1'b1, 20'hA1, 20'hB2, 20'hC3, 7'd3, 1'b0, 3, 7'd3};
    vecs[1] = '{"restart_len1", 1'b0, 20'hA1, 20'hB2, 20'hC3, 7'd1, 1'b0, 1, 7'd1};
    vecs[2] = '{"blocked_ctrl", 1'b1, 20'hA1, 20'hB2, 20'hC3, 7'd3, 1'b1, 3, 7'd3};
    vecs[3] = '{"zero_halt",    1'b1, 20'h11, 20'h00, 20'h22, 7'd3, 1'b0, 1, 7'd1};

    #2;
    check("rst_opcode",  32'(OpCode),  32'd0);
    check("rst_pc",      32'(Pc),      32'd0);
    check("rst_issued",  32'(Issued),  32'd0);
    check("rst_running", 32'(Running), 32'd0);
    check("rst_halted",  32'(Halted),  32'd0);
    tick();
    Reset = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].load) begin
        load(6'd0, vecs[v].w0);
        load(6'd1, vecs[v].w1);
        load(6'd2, vecs[v].w2);
      end
      exp_ops[0] = vecs[v].w0;
      exp_ops[1] = vecs[v].w1;
      exp_ops[2] = vecs[v].w2;
      exp_n = vecs[v].n_issue;
      start(vecs[v].len);
      check({vecs[v].name, "_lat0"},    32'(OpCode),  32'd0);
      check({vecs[v].name, "_running"}, 32'(Running), 32'd1);
      serve(vecs[v].name, vecs[v].poke, n);
      check({vecs[v].name, "_count"},   32'(n),       32'(vecs[v].n_issue));
      check({vecs[v].name, "_halted"},  32'(Halted),  32'd1);
      check({vecs[v].name, "_end_pc"},  32'(Pc),      32'(vecs[v].pc_end));
      check({vecs[v].name, "_issued"},  32'(Issued),  32'(vecs[v].n_issue));
      check({vecs[v].name, "_end_op"},  32'(OpCode),  32'd0);
    end

    // Zero-length program goes straight to HALT.
    start(7'd0);
    check("len0_halted",  32'(Halted),  32'd1);
    check("len0_running", 32'(Running), 32'd0);

    // Load and Start in the same cycle: Start must see the new word.
    LoadEn = 1'b1; LoadAddr = 6'd0; LoadData = 20'h5A;
    start(7'd1);
    LoadEn = 1'b0;
    exp_ops[0] = 20'h5A;
    exp_n = 1;
    serve("load_start", 1'b0, n);
    check("load_start_count", 32'(n), 32'd1);

    // Reset while waiting for Done on instruction 2.
    load(6'd0, 20'hA1);
    load(6'd1, 20'hB2);
    load(6'd2, 20'hC3);
    start(7'd3);
    tick();
    Done = 1'b0; tick();
    Done = 1'b1; tick();
    tick();
    check("mid_op2", 32'(OpCode), 32'hB2);
    Done = 1'b0; tick();
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_opcode",  32'(OpCode),  32'd0);
    check("mid_rst_pc",      32'(Pc),      32'd0);
    check("mid_rst_running", 32'(Running), 32'd0);
    #2 Reset = 1'b0;
    Done = 1'b1;
    tick();
    exp_ops[0] = 20'hA1; exp_ops[1] = 20'hB2; exp_ops[2] = 20'hC3;
    exp_n = 3;
    start(7'd3);
    serve("after_rst", 1'b0, n);
    check("after_rst_count", 32'(n), 32'd3);

    // Full-depth run ends at DEPTH with no wrap back to address 0.
    for (int i = 0; i < DEPTH; i++) begin
      exp_ops[i] = 20'h10000 + OP_W'(i);
      load(AW'(i), exp_ops[i]);
    end
    exp_n = DEPTH;
    start(7'd64);
    serve("full", 1'b0, n);
    check("full_count",  32'(n),      32'd64);
    check("full_pc",     32'(Pc),     32'd64);
    check("full_issued", 32'(Issued), 32'd64);
    check("full_halted", 32'(Halted), 32'd1);
    tick();
    check("full_no_wrap", 32'(OpCode), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
